mdu_stage: RTL and testbench
============================

# mdu_stage

Multiply/divide unit in the E stage, beside the ALU and directly upstream of the E→M pipeline register. It executes MULT/MULTU/DIV/DIVU as fixed-latency multi-cycle operations and MTHI/MTLO as single-cycle writes. It owns the architectural HI/LO registers and raises `busy` so the hazard unit can stall dependent instructions. HI/LO values are muxed onto the E-stage result bus for MFHI/MFLO.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU. Range 1..255.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU. Range 1..255.

- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  op valid this cycle. Driven only for an un-flushed E-stage MD instruction.
- `md_op`  in  3  operation code:
  - 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO.
  - 000 and 111 are no-ops.
- `rs_val`  in  32  forwarded rs operand: multiplicand, dividend, or MTHI/MTLO data.
- `rt_val`  in  32  forwarded rt operand: multiplier or divisor.
- `busy`  out  1  multi-cycle operation in progress.
- `hi`  out  32  architectural HI, registered.
- `lo`  out  32  architectural LO, registered.

## Operation
- States: IDLE and BUSY. `busy` = (state == BUSY).
- **Accept rule.** An op is accepted when `start`=1, state=IDLE, and `md_op` is 001–110. Otherwise no state change.
  - `start` during BUSY is ignored. The hazard unit guarantees this never occurs; verification checks the ignore behaviour.
- **MULT/MULTU/DIV/DIVU accepted:**
  - The result is computed from the operands at the accept edge and held in internal `res_hi`/`res_lo`.
  - Counter loads MULT_CYCLES or DIV_CYCLES (8 bits). State goes to BUSY.
- **MTHI/MTLO accepted:** `hi` or `lo` ← `rs_val` at that edge. The other register is unchanged. State stays IDLE.
- **BUSY:** the counter decrements each cycle. When the counter is 1:
  - `hi` ← `res_hi` and `lo` ← `res_lo`.
  - Counter → 0, state → IDLE.
- **MULT:** signed 32×32 → 64. HI = [63:32], LO = [31:0].
- **MULTU:** unsigned 32×32 → 64, same split.
- **DIV:** signed division, quotient truncated toward zero. LO = quotient; HI = remainder, carrying the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0x00000000.
- **DIVU:** unsigned division. LO = quotient, HI = remainder.
- **Divisor zero (DIV or DIVU):** the busy period still runs its full length. At completion HI/LO are left unchanged.
- `hi`/`lo` never change while BUSY except at the completion edge.
- **Hazard-unit contract (external):** stall the D stage on an MD-class instruction when `busy` | (`start` & E-stage op is MULT/MULTU/DIV/DIVU).

## Timing
- Reset values: state IDLE, `busy`=0, counter 0, `hi`=0, `lo`=0, `res_hi`/`res_lo`=0.
- `reset` wins over every other input, including mid-operation. An in-flight result is discarded and HI/LO read 0 in the next cycle.
- **Multi-cycle op accepted at edge of cycle T:**
  - `busy`=1 in cycles T+1 … T+N, where N = MULT_CYCLES or DIV_CYCLES.
  - New `hi`/`lo` and `busy`=0 are both visible in cycle T+N+1.
- **Back-to-back:** a new op may be accepted in cycle T+N+1, the first cycle with `busy`=0. Minimum spacing between accepted multi-cycle ops is N+1 cycles.
- **MTHI/MTLO** accepted at edge of cycle T: new value visible in cycle T+1.
- `hi`/`lo` are registered with no combinational path from inputs. `busy` is registered.

## Test plan
- **Reset then MULT.** Reset 2 cycles, then `start`, MULT, rs=0xFFFFFFFE (−2), rt=3.
  - `busy`=1 for exactly 5 cycles.
  - Next cycle: `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA, `busy`=0.
- **MULTU.** MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF → after 5 busy cycles `hi`=0xFFFFFFFE, `lo`=0x00000001.
- **Signed/unsigned DIV.**
  - DIV rs=−7 (0xFFFFFFF9), rt=2 → 10 busy cycles, then `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIVU same operands → `lo`=0x7FFFFFFC, `hi`=0x00000001.
- **Divide-by-zero and overflow.**
  - MTHI 0x11111111, MTLO 0x22222222, then DIV rt=0 → 10 busy cycles, HI/LO unchanged.
  - DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- **Ignore while busy.** Start MULT 6×7. During cycle 3 of busy assert `start` with DIVU 100/3 and, separately, with MTLO 0x55.
  - Both are ignored; final `hi`=0, `lo`=42.
  - Then MTHI 0xABCD while idle → `hi`=0xABCD next cycle, `lo`=42.
- **Reset mid-op.** DIV 100/7 accepted; assert `reset` in busy cycle 4.
  - Next cycle: `busy`=0, `hi`=0, `lo`=0.
  - No later completion write occurs.

Source files
------------

// File: rtl/mdu_stage.sv
// rtl/mdu_stage.sv - E-stage multiply/divide unit owning HI/LO with fixed-latency busy window
// Results are computed at accept and parked in res_hi/res_lo until the counter expires.
module mdu_stage #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic        skip_q, skip_d;

  logic        accept, is_mul, is_div, done;
  logic [63:0] prod_s, prod_u;
  logic [31:0] quo_s, rem_s, quo_u, rem_u;
  logic [31:0] calc_hi, calc_lo;

  assign accept = start && (state_q == S_IDLE) && (md_op != 3'b000) && (md_op != 3'b111);
  assign is_mul = (md_op == OP_MULT) || (md_op == OP_MULTU);
  assign is_div = (md_op == OP_DIV) || (md_op == OP_DIVU);

  assign prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
  assign prod_u = {32'b0, rs_val} * {32'b0, rt_val};

  // Zero divisor and the single signed-overflow case are resolved explicitly.
  always_comb begin
    quo_s = 32'b0;
    rem_s = 32'b0;
    quo_u = 32'b0;
    rem_u = 32'b0;
    if (rt_val != 32'b0) begin
      quo_u = rs_val / rt_val;
      rem_u = rs_val % rt_val;
      if (rs_val == 32'h8000_0000 && rt_val == 32'hFFFF_FFFF) begin
        quo_s = 32'h8000_0000;
        rem_s = 32'b0;
      end else begin
        quo_s = $signed(rs_val) / $signed(rt_val);
        rem_s = $signed(rs_val) % $signed(rt_val);
      end
    end
  end

  always_comb begin
    calc_hi = 32'b0;
    calc_lo = 32'b0;
    case (md_op)
      OP_MULT:  begin calc_hi = prod_s[63:32]; calc_lo = prod_s[31:0]; end
      OP_MULTU: begin calc_hi = prod_u[63:32]; calc_lo = prod_u[31:0]; end
      OP_DIV:   begin calc_hi = rem_s;         calc_lo = quo_s;        end
      OP_DIVU:  begin calc_hi = rem_u;         calc_lo = quo_u;        end
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      hi_q     <= 32'b0;
      lo_q     <= 32'b0;
      res_hi_q <= 32'b0;
      res_lo_q <= 32'b0;
      skip_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      skip_q   <= skip_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept && (is_mul || is_div)) begin
          state_d = S_BUSY;
          cnt_d   = is_mul ? 8'(MULT_CYCLES) : 8'(DIV_CYCLES);
        end
      end
      S_BUSY: begin
        if (cnt_q == 8'd1) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_BUSY);
    done = (state_q == S_BUSY) && (cnt_q == 8'd1);
  end

  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    skip_d   = skip_q;
    if (accept && (is_mul || is_div)) begin
      res_hi_d = calc_hi;
      res_lo_d = calc_lo;
      skip_d   = is_div && (rt_val == 32'b0);
    end else if (accept && md_op == OP_MTHI) begin
      hi_d = rs_val;
    end else if (accept && md_op == OP_MTLO) begin
      lo_d = rs_val;
    end
    if (done && !skip_q) begin
      hi_d = res_hi_q;
      lo_d = res_lo_q;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_mdu_stage.sv
// tb/tb_mdu_stage.sv - directed vector bench for mdu_stage
module tb_mdu_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mdu_stage #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .md_op  (md_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cycles;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Drive one op at the negedge, then count busy cycles after the accept edge.
  task automatic run_op(input string name, input vec_t v);
    int n;
    logic held;
    logic [31:0] h0, l0;
    h0 = hi;
    l0 = lo;
    held = 1'b1;
    @(negedge clk);
    start = 1'b1; md_op = v.op; rs_val = v.rs; rt_val = v.rt;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'b000; rs_val = 32'h0; rt_val = 32'h0;
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      if (hi !== h0 || lo !== l0) held = 1'b0;
      n++;
      @(posedge clk); #1;
    end
    check({name, " busy_cycles"}, 32'(n), 32'(v.exp_cycles));
    check({name, " hold_while_busy"}, {31'b0, held}, 32'd1);
    check({name, " hi"}, hi, v.exp_hi);
    check({name, " lo"}, lo, v.exp_lo);
    check({name, " busy_after"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    vec_t v;
    logic ok;
    vecs[0]  = '{3'b001, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[2]  = '{3'b001, 32'hFFFFFFF9, 32'hFFFFFFFA, 32'h00000000, 32'h0000002A, 5};
    vecs[3]  = '{3'b010, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'hFFFFFFF2, 5};
    vecs[4]  = '{3'b011, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[5]  = '{3'b100, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 10};
    vecs[6]  = '{3'b011, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[7]  = '{3'b101, 32'h11111111, 32'h00000000, 32'h11111111, 32'hFFFFFFFD, 0};
    vecs[8]  = '{3'b110, 32'h22222222, 32'h00000000, 32'h11111111, 32'h22222222, 0};
    vecs[9]  = '{3'b011, 32'h00000005, 32'h00000000, 32'h11111111, 32'h22222222, 10};
    vecs[10] = '{3'b100, 32'h00000005, 32'h00000000, 32'h11111111, 32'h22222222, 10};
    vecs[11] = '{3'b000, 32'hDEADBEEF, 32'h00000001, 32'h11111111, 32'h22222222, 0};
    vecs[12] = '{3'b111, 32'hDEADBEEF, 32'h00000001, 32'h11111111, 32'h22222222, 0};
    vecs[13] = '{3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[14] = '{3'b100, 32'h00000064, 32'h00000003, 32'h00000001, 32'h00000021, 10};

    reset = 1'b1; start = 1'b0; md_op = 3'b000; rs_val = 32'h0; rt_val = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) run_op($sformatf("vec%0d", i), vecs[i]);

    // MULT 6x7 with DIVU and MTLO offered during busy cycles 3 and 4.
    @(negedge clk);
    start = 1'b1; md_op = 3'b001; rs_val = 32'd6; rt_val = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("ign busy_c3", {31'b0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b1; md_op = 3'b100; rs_val = 32'd100; rt_val = 32'd3;
    @(posedge clk); #1;
    @(negedge clk);
    start = 1'b1; md_op = 3'b110; rs_val = 32'h55; rt_val = 32'h0;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'b000;
    check("ign busy_c5", {31'b0, busy}, 32'd1);
    check("ign lo_c5", lo, 32'h00000021);
    check("ign hi_c5", hi, 32'h00000001);
    @(posedge clk); #1;
    check("ign busy_done", {31'b0, busy}, 32'd0);
    check("ign hi", hi, 32'h0);
    check("ign lo", lo, 32'd42);
    repeat (12) begin
      @(posedge clk); #1;
    end
    check("ign no_late_busy", {31'b0, busy}, 32'd0);
    check("ign lo_stable", lo, 32'd42);
    v = '{3'b101, 32'h0000ABCD, 32'h0, 32'h0000ABCD, 32'd42, 0};
    run_op("mthi_idle", v);

    // Reset asserted during busy cycle 4 of DIV 100/7.
    @(negedge clk);
    start = 1'b1; md_op = 3'b011; rs_val = 32'd100; rt_val = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'b000;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("rst busy_c4", {31'b0, busy}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst busy", {31'b0, busy}, 32'd0);
    check("rst hi", hi, 32'h0);
    check("rst lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    ok = 1'b1;
    repeat (15) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) ok = 1'b0;
    end
    check("rst no_late_write", {31'b0, ok}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
